// File: rtl/mul4_seq_ctrl.sv
// Sequential 2Wx2W -> 4W unsigned limb multiplier: one shared WxW multiplier, one partial product per cycle.
// Optional MUL4_ZERO_SKIP_EN: steps whose a- or b-limb is zero are skipped.
module mul4_seq_ctrl #(
    parameter int W     = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b1,
    input  logic [W-1:0]     b0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     y3,
    output logic [W-1:0]     y2,
    output logic [W-1:0]     y1,
    output logic [W-1:0]     y0,
    output logic [CNT_W-1:0] mul_count
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t state, state_nx;

    logic [W-1:0]   ra1, ra0, rb1, rb0;
    logic [4*W-1:0] acc;
    logic [1:0]     s;
    logic [3:0]     in_mask;   // bit i set: step i runs for the incoming operands
    logic [3:0]     mask;      // same, for the operation in flight
    logic [1:0]     first_idx, next_idx;
    logic           has_first, has_next;
    logic [W-1:0]   op_a, op_b;
    logic [2*W-1:0] pp;
    logic [4*W-1:0] pp_ext, pp_sh;

`ifdef MUL4_ZERO_SKIP_EN
    assign in_mask = {(a1 != '0) && (b1 != '0), (a1 != '0) && (b0 != '0),
                      (a0 != '0) && (b1 != '0), (a0 != '0) && (b0 != '0)};
`else
    assign in_mask = 4'hF;
    assign mask    = 4'hF;
`endif

    // Lowest step to run at accept, and next step to run after the current one.
    always_comb begin
        first_idx = 2'd0;
        has_first = 1'b0;
        next_idx  = 2'd0;
        has_next  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (in_mask[i]) begin
                first_idx = 2'(i);
                has_first = 1'b1;
            end
            if (mask[i] && (i > int'(s))) begin
                next_idx = 2'(i);
                has_next = 1'b1;
            end
        end
    end

    // Step s: a-limb chosen by s[1], b-limb by s[0]; shift is (s[1]+s[0])*W.
    always_comb begin
        op_a   = s[1] ? ra1 : ra0;
        op_b   = s[0] ? rb1 : rb0;
        pp     = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
        pp_ext = {{(2*W){1'b0}}, pp};
        pp_sh  = pp_ext;
        case (s)
            2'd0:    pp_sh = pp_ext;
            2'd3:    pp_sh = pp_ext << (2*W);
            default: pp_sh = pp_ext << W;
        endcase
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = has_first ? MUL : DONE;
            end
            MUL: begin
                if (!has_next) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            s         <= 2'd0;
            mul_count <= '0;
            ra1       <= '0;
            ra0       <= '0;
            rb1       <= '0;
            rb0       <= '0;
`ifdef MUL4_ZERO_SKIP_EN
            mask      <= 4'h0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra1 <= a1;
                        ra0 <= a0;
                        rb1 <= b1;
                        rb0 <= b0;
                        acc <= '0;
                        s   <= first_idx;
`ifdef MUL4_ZERO_SKIP_EN
                        mask <= in_mask;
`endif
                    end
                end
                MUL: begin
                    acc       <= acc + pp_sh;
                    mul_count <= mul_count + CNT_W'(1);
                    s         <= next_idx;
                end
                default: ;
            endcase
        end
    end

    assign y3 = acc[4*W-1:3*W];
    assign y2 = acc[3*W-1:2*W];
    assign y1 = acc[2*W-1:W];
    assign y0 = acc[W-1:0];

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// Scoreboard bench for mul4_seq_ctrl: driver pushes hand-computed products, a forked monitor checks each presented result.
module tb_mul4_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;
    logic [31:0] mul_count;

    typedef struct {
        logic [63:0] y;
        int          lat;
        int          cyc;
        logic [31:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cnt_model = 0;
    int          last_acc = 0;
    int          last_lat = 0;

    mul4_seq_ctrl #(.W(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a1(a1), .a0(a0), .b1(b1), .b0(b0),
        .out_valid(out_valid), .out_ready(out_ready),
        .y3(y3), .y2(y2), .y1(y1), .y0(y0), .mul_count(mul_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic monitor();
        bit   pv = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) pv = 1'b0;
            else begin
                if (out_valid && !pv) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %h expected none", {y3, y2, y1, y0});
                    end else begin
                        e = q.pop_front();
                        check("product", {y3, y2, y1, y0}, e.y);
                        check("latency", 64'(cyc - e.cyc), 64'(e.lat));
                        check("mul_count", 64'(mul_count), 64'(e.cnt));
                    end
                end
                pv = out_valid;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge one cycle after the accept.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] y,
                         input int n, input bit keep, input bit gap_chk);
        exp_t e;
        int   k = 0;
        int   steps;
        in_valid = 1'b1;
        {a1, a0} = a;
        {b1, b0} = b;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
            in_valid = 1'b0;
            return;
        end
`ifdef MUL4_ZERO_SKIP_EN
        steps = n;
`else
        steps = 4;
`endif
        cnt_model += 32'(steps);
        e.y = y; e.lat = steps + 1; e.cyc = cyc; e.cnt = cnt_model;
        q.push_back(e);
        if (gap_chk) check("accept_gap", 64'(cyc - last_acc), 64'(last_lat + 1));
        last_acc = cyc;
        last_lat = steps + 1;
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        @(negedge clk);
    endtask

    task automatic reset_checks();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_y", {y3, y2, y1, y0}, 64'd0);
        check("rst_mul_count", 64'(mul_count), 64'd0);
    endtask

    initial begin
        int k;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a1 = '0; a0 = '0; b1 = '0; b0 = '0;
        fork monitor(); join_none
        repeat (2) @(negedge clk);
        rst = 1'b0;
        reset_checks();

        issue(32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008, 4, 0, 0);
        drain();
        issue(32'h0000_0005, 32'h0000_0007, 64'h0000_0000_0000_0023, 1, 0, 0);
        drain();
        issue(32'h0000_0000, 32'h1234_5678, 64'h0, 0, 0, 0);
        drain();

        // Backpressure: result must hold while inputs churn.
        out_ready = 1'b0;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4, 0, 0);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            {a1, a0} = $urandom;
            {b1, b0} = $urandom;
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_y", {y3, y2, y1, y0}, 64'hFFFF_FFFE_0000_0001);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);

        // Reset in cycle T+2 of an operation.
        issue(32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008, 4, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        cnt_model = 0;
        @(negedge clk);
        rst = 1'b0;
        reset_checks();
        issue(32'h0000_0002, 32'h0000_0003, 64'h6, 1, 0, 0);
        drain();

        // Back-to-back from a fresh counter.
        rst = 1'b1;
        cnt_model = 0;
        @(negedge clk);
        rst = 1'b0;
        issue(32'h0002_0003, 32'h0004_0005, 64'h0000_0008_0016_000F, 4, 1, 0);
        issue(32'h1234_0000, 32'h0000_0010, 64'h0000_0001_2340_0000, 1, 1, 1);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 2, 0, 1);
        drain();
        check("final_mul_count", 64'(mul_count), 64'(cnt_model));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul4_seq_ctrl.md
Name: mul4_seq_ctrl

Overview:
- Sequencer that computes the 4W-bit product {a1,a0} × {b1,b0} with one shared W×W multiplier, used once per step.
- Limb operands are taken in over a valid/ready handshake.
- The partial products are accumulated and presented as four W-bit result limbs y3..y0, held until consumed.
- Sits in front of the mul4_vector datapath. It is the multi-cycle, area-reduced counterpart to the combinational limb multiplier.

Parameters:
- W, 16, limb width in bits. Operands are 2W bits, the product is 4W bits.
- CNT_W, 32, width of the multiplier-use counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand limbs valid
- in_ready  output  1  block can accept operands
- a1  input  W  operand A, high limb
- a0  input  W  operand A, low limb
- b1  input  W  operand B, high limb
- b0  input  W  operand B, low limb
- out_valid  output  1  y3..y0 hold a completed product
- out_ready  input  1  consumer takes the result
- y3  output  W  product bits [4W-1:3W]
- y2  output  W  product bits [3W-1:2W]
- y1  output  W  product bits [2W-1:W]
- y0  output  W  product bits [W-1:0]
- mul_count  output  CNT_W  number of multiplier steps executed since reset

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; the accumulator and y3..y0 clear to 0.
  - out_valid=0 and mul_count=0.
  - in_ready is 1 in the first cycle after reset.
  - A reset mid-operation aborts the operation; no partial result is ever presented.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - MUL: in_ready=0, out_valid=0; 2-bit step index s.
  - DONE: in_ready=0, out_valid=1.
- IDLE → MUL:
  - Occurs on an edge where in_valid && in_ready.
  - The operand limbs are captured into internal registers, the accumulator clears, and s=0.
  - Inputs are ignored while the block is not in IDLE.
- MUL, one step per cycle, in fixed order:
  - s=0: a0·b0 added at shift 0.
  - s=1: a0·b1 added at shift W.
  - s=2: a1·b0 added at shift W.
  - s=3: a1·b1 added at shift 2W.
  - Each step is acc ← acc + (pp << shift), with a 4W-bit accumulator. Carries never exceed 4W bits (the maximum product fits).
  - Each executed step increments mul_count by 1. mul_count wraps modulo 2^CNT_W.
  - The edge that completes s=3 moves the state to DONE.
- Latency:
  - Accept edge at end of cycle T. Steps run in cycles T+1..T+4.
  - out_valid=1 from cycle T+5.
- y3..y0 are registered and continuously driven from the accumulator:
  - They show intermediate values during MUL.
  - They are stable and complete whenever out_valid=1.
  - They retain the last result in IDLE until the next accept clears them.
- DONE → IDLE:
  - Occurs on an edge with out_ready=1; out_valid drops in the next cycle.
  - out_valid and y are held for as long as out_ready=0 (backpressure, no timeout).
  - There is no bypass: in_ready is 0 in the cycle where out_valid && out_ready. The earliest next accept is one cycle later, giving a minimum issue interval of 6 cycles.
- Arithmetic is unsigned only.

Optional Feature:
- Macro: MUL4_ZERO_SKIP_EN.
- When defined:
  - At accept, every step whose a-limb or b-limb is zero is marked skipped.
  - MUL visits only the non-skipped steps, in the same order, one per cycle. The last executed step moves the state to DONE.
  - If all four steps are skipped (A=0 or B=0), the state goes IDLE → DONE directly: out_valid at T+1 and y=0.
  - mul_count counts executed steps only.
  - Latency is T+1+n, where n is the number of non-skipped steps (0..4).
- When undefined: all four steps always execute, latency is always T+5, and mul_count advances by 4 per operation.

Test Plan:
- Basic product:
  - Stimulus: a1=0x0001, a0=0x0002, b1=0x0003, b0=0x0004, out_ready=1.
  - Response: y3=0x0000, y2=0x0003, y1=0x000A, y0=0x0008; out_valid exactly at T+5; mul_count=4.
- Maximum operands:
  - Stimulus: all limbs 0xFFFF.
  - Response: y3=0xFFFF, y2=0xFFFE, y1=0x0000, y0=0x0001 (accumulator carry propagation).
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid, toggling in_valid and the operands meanwhile.
  - Response: y3..y0 and out_valid are unchanged and in_ready=0 throughout. Releasing out_ready gives in_ready=1 one cycle later.
- Reset mid-operation:
  - Stimulus: assert rst at T+2 of an operation.
  - Response: next cycle has out_valid=0, y3..y0=0, mul_count=0, in_ready=1. A following operation 0x0000_0002 × 0x0000_0003 gives y0=0x0006.
- Zero skip:
  - Stimulus: a1=0, a0=5, b1=0, b0=7, with MUL4_ZERO_SKIP_EN defined.
  - Response: y0=0x0023, other limbs 0; out_valid at T+2; mul_count=1.
  - Without the macro: same result at T+5 with mul_count=4.
  - With A=0 and the macro defined: out_valid at T+1, y=0, mul_count unchanged.
- Back-to-back:
  - Stimulus: in_valid and out_ready held high for 3 operations.
  - Response: accepts spaced exactly 6 cycles apart, each result correct, mul_count=12.
